// File: rtl/counter_pkg.sv
// Shared types and width helpers for the up/down counter family.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP,
    CNT_SAT
  } cnt_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One spare bit so v+s and v+(MAX_VALUE+1) never lose their carry.
  function automatic int arith_width(input int width, input int step_width);
    return max_int(width, step_width) + 1;
  endfunction

endpackage

// File: rtl/counter_updown_next.sv
// Combinational next-value and boundary-flag calculator for counter_updown.
module counter_updown_next
  import counter_pkg::*;
#(
  parameter int                WIDTH      = 8,
  parameter int                STEP_WIDTH = 4,
  parameter logic [WIDTH-1:0]  MAX_VALUE  = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0]      value,
  input  logic                  up,
  input  cnt_mode_t             mode,
  input  logic [STEP_WIDTH-1:0] step,
  output logic [WIDTH-1:0]      next_value,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            AW      = arith_width(WIDTH, STEP_WIDTH);
  localparam logic [AW-1:0] MAX_A   = AW'(MAX_VALUE);
  localparam logic [AW-1:0] RANGE_A = MAX_A + AW'(1);

  logic [AW-1:0] v;
  logic [AW-1:0] s_raw;
  logic [AW-1:0] s;
  logic [AW-1:0] res;

  // NOTE: every output of this block gets a default before any branch, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    v         = AW'(value);
    s_raw     = AW'(step);
    s         = (s_raw > MAX_A) ? MAX_A : s_raw;
    res       = v;
    overflow  = 1'b0;
    underflow = 1'b0;

    if (up) begin
      res = v + s;
      if (res > MAX_A) begin
        overflow = 1'b1;
        res      = (mode == CNT_SAT) ? MAX_A : res - RANGE_A;
      end
    end else if (v >= s) begin
      res = v - s;
    end else begin
      underflow = 1'b1;
      res       = (mode == CNT_SAT) ? '0 : v + RANGE_A - s;
    end

    next_value = WIDTH'(res);
  end

endmodule

// File: rtl/counter_updown.sv
// Up/down counter: registers plus the clear/load/count priority mux.
// Compare output is built only when COUNTER_UPDOWN_CMP_EN is defined.
module counter_updown
  import counter_pkg::*;
#(
  parameter int                WIDTH      = 8,
  parameter int                STEP_WIDTH = 4,
  parameter logic [WIDTH-1:0]  MAX_VALUE  = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enabled,
  input  logic                  up,
  input  cnt_mode_t             mode,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      cmp_value,
  output logic [WIDTH-1:0]      value,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  match
);

  logic [WIDTH-1:0] calc_value;
  logic             calc_overflow;
  logic             calc_underflow;

  logic [WIDTH-1:0] value_d;
  logic             overflow_d;
  logic             underflow_d;
  logic             match_d;

  counter_updown_next #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH),
    .MAX_VALUE  (MAX_VALUE)
  ) u_next (
    .value      (value),
    .up         (up),
    .mode       (mode),
    .step       (step),
    .next_value (calc_value),
    .overflow   (calc_overflow),
    .underflow  (calc_underflow)
  );

  always_comb begin
    value_d     = value;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clear) begin
      value_d = '0;
    end else if (load) begin
      value_d = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    end else if (enabled) begin
      value_d     = calc_value;
      overflow_d  = calc_overflow;
      underflow_d = calc_underflow;
    end
  end

`ifdef COUNTER_UPDOWN_CMP_EN
  // Compare against the value being registered so match lines up with value.
  assign match_d = (value_d == cmp_value);
`else
  logic unused_cmp;
  assign unused_cmp = ^cmp_value;
  assign match_d    = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      match     <= 1'b0;
    end else begin
      value     <= value_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
      match     <= match_d;
    end
  end

endmodule

// File: tb/tb_counter_updown.sv
// Directed self-checking bench for counter_updown (WIDTH=4, STEP_WIDTH=4, MAX_VALUE=9).
module tb_counter_updown;
  import counter_pkg::*;

`ifdef COUNTER_UPDOWN_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enabled;
  logic       up;
  cnt_mode_t  mode;
  logic [3:0] step;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] cmp_value;
  logic [3:0] value;
  logic       overflow;
  logic       underflow;
  logic       match;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_updown #(
    .WIDTH      (4),
    .STEP_WIDTH (4),
    .MAX_VALUE  (4'd9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enabled    (enabled),
    .up         (up),
    .mode       (mode),
    .step       (step),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .cmp_value  (cmp_value),
    .value      (value),
    .overflow   (overflow),
    .underflow  (underflow),
    .match      (match)
  );

  // Outputs packed as {value, overflow, underflow, match}.
  function automatic logic [6:0] obs();
    return {value, overflow, underflow, match};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; enabled = 1'b0; up = 1'b1; mode = CNT_WRAP; step = 4'd1;
    clear = 1'b0; load = 1'b0; load_value = 4'd0; cmp_value = 4'd15;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    idle_inputs();
    rst = 1'b1;
    cmp_value = 4'd0;
    tick();
    tick();
    exp = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs(), exp);
    end
    rst = 1'b0;
    cmp_value = 4'd15;
  endtask

  task automatic test_wrap_up();
    logic [6:0] exp;
    enabled = 1'b1; up = 1'b1; mode = CNT_WRAP; step = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (i < 9) ? {4'(i + 1), 1'b0, 1'b0, 1'b0} : {4'd0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got %h expected %h", i, obs(), exp);
      end
    end
    enabled = 1'b0;
  endtask

  task automatic test_wrap_down();
    logic [6:0] exp;
    load = 1'b1; load_value = 4'd1;
    tick();
    load = 1'b0;
    enabled = 1'b1; up = 1'b0; mode = CNT_WRAP; step = 4'd3;
    tick();
    exp = {4'd8, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL wrap_down_cross: got %h expected %h", obs(), exp);
    end
    tick();
    exp = {4'd5, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL wrap_down_next: got %h expected %h", obs(), exp);
    end
    enabled = 1'b0;
  endtask

  task automatic test_saturate();
    logic [6:0] exp;
    load = 1'b1; load_value = 4'd7;
    tick();
    load = 1'b0;
    enabled = 1'b1; up = 1'b1; mode = CNT_SAT; step = 4'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = {4'd9, 1'b1, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL sat_up[%0d]: got %h expected %h", i, obs(), exp);
      end
    end
    // step 12 clips to 9; 9-9 lands exactly on 0
    up = 1'b0; step = 4'd12;
    tick();
    checks++;
    if (value !== 4'd0) begin
      errors++;
      $display("FAIL sat_down_value: got %0d expected 0", value);
    end
    // already at 0: the clipping step flags again
    tick();
    exp = {4'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL sat_down_limit: got %h expected %h", obs(), exp);
    end
    enabled = 1'b0;
    mode = CNT_WRAP;
  endtask

  task automatic test_priority();
    logic [6:0] exp;
    load = 1'b1; load_value = 4'd12; enabled = 1'b1; up = 1'b1; step = 4'd1;
    tick();
    exp = {4'd9, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL load_clip: got %h expected %h", obs(), exp);
    end
    clear = 1'b1; load_value = 4'd3;
    tick();
    exp = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL clear_over_load: got %h expected %h", obs(), exp);
    end
    clear = 1'b0; load = 1'b0; step = 4'd0;
    for (int i = 0; i < 2; i++) begin
      up = (i == 0);
      tick();
      exp = {4'd0, 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL step_zero[%0d]: got %h expected %h", i, obs(), exp);
      end
    end
    enabled = 1'b0;
    step = 4'd1;
  endtask

  task automatic test_compare_reset();
    logic [6:0] exp;
    cmp_value = 4'd5; up = 1'b1; mode = CNT_WRAP; step = 4'd1; enabled = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {4'(i), 1'b0, 1'b0, CMP_EN && (i == 5)};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL compare[%0d]: got %h expected %h", i, obs(), exp);
      end
    end
    // reset outranks load; cmp_value=0 must not raise match out of reset
    rst = 1'b1; load = 1'b1; load_value = 4'd4; cmp_value = 4'd0;
    tick();
    exp = {4'd0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", obs(), exp);
    end
    rst = 1'b0; load = 1'b0; enabled = 1'b0;
    tick();
    exp = {4'd0, 1'b0, 1'b0, CMP_EN};
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL match_after_reset: got %h expected %h", obs(), exp);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_compare_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
